// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALU/PC/operand selects.
package mc_ctrl_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned ALU_ENC_W = 3;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        CL_R, CL_ADDI, CL_BEQ, CL_BNE, CL_LUI, CL_ORI,
        CL_SLTIU, CL_LW, CL_SW, CL_J, CL_BAD
    } op_class_e;

    localparam logic [ALU_ENC_W-1:0] ALU_R     = 3'b000;
    localparam logic [ALU_ENC_W-1:0] ALU_ADD   = 3'b001;
    localparam logic [ALU_ENC_W-1:0] ALU_BEQ   = 3'b010;
    localparam logic [ALU_ENC_W-1:0] ALU_BNE   = 3'b011;
    localparam logic [ALU_ENC_W-1:0] ALU_LUI   = 3'b100;
    localparam logic [ALU_ENC_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALU_ENC_W-1:0] ALU_SLTIU = 3'b110;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    // Operand B select: 1 (constant 4) is reserved for the PC incrementer path.
    localparam logic [1:0] SRC_B_REG = 2'd0;
    localparam logic [1:0] SRC_B_IMM = 2'd2;

    typedef struct packed {
        logic [ALU_ENC_W-1:0] alu_op;
        logic [1:0]           alu_src_b;
        logic                 alu_src_a;
        logic                 zero_ext;
        logic                 lui;
        logic                 sltiu;
    } ex_ctrl_t;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode decoder: instruction class plus the ALU controls used in EX.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output op_class_e       cls_o,
    output ex_ctrl_t        ctrl_o,
    output logic            valid_o
);

    always_comb begin
        cls_o  = CL_BAD;
        ctrl_o = '0;
        case (op_i)
            OP_RTYPE: begin
                cls_o = CL_R;
                ctrl_o.alu_op = ALU_R;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
            end
            OP_ADDI: begin
                cls_o = CL_ADDI;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
            end
            OP_BEQ: begin
                cls_o = CL_BEQ;
                ctrl_o.alu_op = ALU_BEQ;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
            end
            OP_BNE: begin
                cls_o = CL_BNE;
                ctrl_o.alu_op = ALU_BNE;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
            end
            OP_LUI: begin
                cls_o = CL_LUI;
                ctrl_o.alu_op = ALU_LUI;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.lui = 1'b1;
            end
            OP_ORI: begin
                cls_o = CL_ORI;
                ctrl_o.alu_op = ALU_OR;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.zero_ext = 1'b1;
            end
            OP_SLTIU: begin
                cls_o = CL_SLTIU;
                ctrl_o.alu_op = ALU_SLTIU;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.zero_ext = 1'b1;
                ctrl_o.sltiu = 1'b1;
            end
            OP_LW, OP_SW: begin
                cls_o = (op_i == OP_LW) ? CL_LW : CL_SW;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
            end
            OP_J: begin
                cls_o = CL_J;
            end
            default: ;
        endcase
    end

    assign valid_o = (cls_o != CL_BAD);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle processor control FSM (IF/ID/EX/MEM/WB/TRAP) with memory-wait
// timeout and a saturating retired-instruction counter.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic [SHAMT_W-1:0]  shamt_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                zero_extend_o,
    output logic                lui_ctrl_o,
    output logic                sltiu_ctrl_o,
    output logic [1:0]          pc_src_o,
    output logic [SHAMT_W-1:0]  shamt_o,
    output logic                trap_o,
    output logic [CNT_W-1:0]    retired_o
);

    localparam int unsigned TO_W = 32;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  opcode_q, opcode_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [OP_W-1:0]  dec_op;
    op_class_e        dec_cls;
    ex_ctrl_t         dec_ctrl;
    logic             dec_valid;
    logic             waiting, timed_out, retire;
    logic             pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    // ID decodes the live opcode; later states use the latched copy.
    assign dec_op = (state_q == ST_ID) ? instr_op_i : opcode_q;

    mc_op_decode u_dec (
        .op_i    (dec_op),
        .cls_o   (dec_cls),
        .ctrl_o  (dec_ctrl),
        .valid_o (dec_valid)
    );

    assign waiting   = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready_i;
    assign timed_out = (MEM_TIMEOUT != 0) && waiting &&
                       (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IF;
            opcode_q  <= '0;
            to_cnt_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            to_cnt_q  <= to_cnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        retire   = 1'b0;
        case (state_q)
            ST_IF: begin
                if (timed_out)        state_d = ST_TRAP;
                else if (mem_ready_i) state_d = ST_ID;
            end
            ST_ID: begin
                opcode_d = instr_op_i;
                state_d  = dec_valid ? ST_EX : ST_TRAP;
            end
            ST_EX: begin
                case (dec_cls)
                    CL_R, CL_ADDI, CL_ORI, CL_SLTIU, CL_LUI: state_d = ST_WB;
                    CL_LW, CL_SW:                            state_d = ST_MEM;
                    CL_BEQ, CL_BNE, CL_J: begin
                        state_d = ST_IF;
                        retire  = 1'b1;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (timed_out) begin
                    state_d = ST_TRAP;
                end else if (mem_ready_i) begin
                    if (dec_cls == CL_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IF;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IF;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase

        to_cnt_d  = waiting ? (to_cnt_q + TO_W'(1)) : '0;
        retired_d = (retire && (retired_q != '1)) ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_comb begin
        pc_write_c    = 1'b0;
        ir_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        mem_read_o    = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = SRC_B_REG;
        alu_op_o      = '0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        zero_extend_o = 1'b0;
        lui_ctrl_o    = 1'b0;
        sltiu_ctrl_o  = 1'b0;
        pc_src_o      = PC_SRC_SEQ;
        shamt_o       = '0;
        trap_o        = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                end
            end
            ST_EX: begin
                alu_op_o      = ALU_OP_W'(dec_ctrl.alu_op);
                alu_src_a_o   = dec_ctrl.alu_src_a;
                alu_src_b_o   = dec_ctrl.alu_src_b;
                zero_extend_o = dec_ctrl.zero_ext;
                lui_ctrl_o    = dec_ctrl.lui;
                sltiu_ctrl_o  = dec_ctrl.sltiu;
                if (dec_cls == CL_R) shamt_o = shamt_i;
                case (dec_cls)
                    CL_BEQ, CL_BNE: begin
                        if (zero_i == (dec_cls == CL_BEQ)) begin
                            pc_write_c = 1'b1;
                            pc_src_o   = PC_SRC_BR;
                        end
                    end
                    CL_J: begin
                        pc_write_c = 1'b1;
                        pc_src_o   = PC_SRC_JMP;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_read_o  = (dec_cls == CL_LW);
                mem_write_c = (dec_cls == CL_SW);
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_o    = (dec_cls == CL_R);
                mem_to_reg_o = (dec_cls == CL_LW);
            end
            ST_TRAP: trap_o = 1'b1;
            default: ;
        endcase
    end

    // Write strobes are masked while reset is held so nothing commits mid-reset.
    assign pc_write_o  = pc_write_c  & ~rst_i;
    assign ir_write_o  = ir_write_c  & ~rst_i;
    assign mem_write_o = mem_write_c & ~rst_i;
    assign reg_write_o = reg_write_c & ~rst_i;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-opcode vector table plus multi-cycle sequences.
module tb_mc_ctrl_fsm;

    logic       clk, rst;
    logic [5:0] instr_op;
    logic [4:0] shamt;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, zero_extend, lui_ctrl, sltiu_ctrl;
    logic [1:0] pc_src;
    logic [4:0] shamt_out;
    logic       trap;
    logic [1:0] retired;

    int n_vec = 0;
    int n_err = 0;

    mc_ctrl_fsm #(.CNT_W(2), .ALU_OP_W(3), .MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .shamt_i(shamt),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .ir_write_o(ir_write), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .zero_extend_o(zero_extend),
        .lui_ctrl_o(lui_ctrl), .sltiu_ctrl_o(sltiu_ctrl), .pc_src_o(pc_src),
        .shamt_o(shamt_out), .trap_o(trap), .retired_o(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [5:0] op;   logic [4:0] sh;  logic z;
        logic [2:0] alu;  logic src_a;     logic [1:0] src_b;
        logic zx;         logic lui;       logic slt;
        logic [4:0] sh_ex; logic pcw;      logic [1:0] pcs;
        logic p_rw;       logic p_rd;      logic p_mr;  logic p_mw;
        logic [1:0] p_ret;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 5'd7, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{6'b001000, 5'd9, 1'b0, 3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{6'b000100, 5'd0, 1'b1, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[3]  = '{6'b000100, 5'd0, 1'b0, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[4]  = '{6'b000101, 5'd0, 1'b1, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[5]  = '{6'b000101, 5'd0, 1'b0, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[6]  = '{6'b001111, 5'd3, 1'b0, 3'd4, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{6'b001101, 5'd0, 1'b0, 3'd5, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{6'b001011, 5'd0, 1'b0, 3'd6, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{6'b100011, 5'd0, 1'b0, 3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[10] = '{6'b101011, 5'd0, 1'b0, 3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[11] = '{6'b000010, 5'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};

        // Reset state, with mem_ready high to confirm write strobes stay masked.
        rst = 1'b1; instr_op = 6'd0; shamt = 5'd0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("rst mem_read", 32'(mem_read), 1);
        chk("rst ir_write", 32'(ir_write), 0);
        chk("rst pc_write", 32'(pc_write), 0);
        chk("rst trap", 32'(trap), 0);
        chk("rst retired", 32'(retired), 0);
        chk("rst alu_op", 32'(alu_op), 0);

        // One instruction per vector: IF, ID, EX, then the following state.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            instr_op = vecs[i].op; shamt = vecs[i].sh; zero = vecs[i].z; mem_ready = 1'b1;
            #1;
            chk($sformatf("v%0d IF ir_write", i), 32'(ir_write), 1);
            chk($sformatf("v%0d IF pc_write", i), 32'(pc_write), 1);
            step();
            chk($sformatf("v%0d ID shamt", i), 32'(shamt_out), 0);
            chk($sformatf("v%0d ID pc_write", i), 32'(pc_write), 0);
            step();
            chk($sformatf("v%0d EX alu_op", i), 32'(alu_op), 32'(vecs[i].alu));
            chk($sformatf("v%0d EX alu_src_a", i), 32'(alu_src_a), 32'(vecs[i].src_a));
            chk($sformatf("v%0d EX alu_src_b", i), 32'(alu_src_b), 32'(vecs[i].src_b));
            chk($sformatf("v%0d EX zero_ext", i), 32'(zero_extend), 32'(vecs[i].zx));
            chk($sformatf("v%0d EX lui", i), 32'(lui_ctrl), 32'(vecs[i].lui));
            chk($sformatf("v%0d EX sltiu", i), 32'(sltiu_ctrl), 32'(vecs[i].slt));
            chk($sformatf("v%0d EX shamt", i), 32'(shamt_out), 32'(vecs[i].sh_ex));
            chk($sformatf("v%0d EX pc_write", i), 32'(pc_write), 32'(vecs[i].pcw));
            chk($sformatf("v%0d EX pc_src", i), 32'(pc_src), 32'(vecs[i].pcs));
            chk($sformatf("v%0d EX reg_write", i), 32'(reg_write), 0);
            step();
            chk($sformatf("v%0d post reg_write", i), 32'(reg_write), 32'(vecs[i].p_rw));
            chk($sformatf("v%0d post reg_dst", i), 32'(reg_dst), 32'(vecs[i].p_rd));
            chk($sformatf("v%0d post mem_read", i), 32'(mem_read), 32'(vecs[i].p_mr));
            chk($sformatf("v%0d post mem_write", i), 32'(mem_write), 32'(vecs[i].p_mw));
            chk($sformatf("v%0d post retired", i), 32'(retired), 32'(vecs[i].p_ret));
            chk($sformatf("v%0d post shamt", i), 32'(shamt_out), 0);
        end

        // addi retires through WB, then an unsupported opcode traps without retiring.
        do_reset();
        instr_op = 6'b001000; mem_ready = 1'b1; #1;
        step(); step(); step();
        chk("addi WB reg_write", 32'(reg_write), 1);
        chk("addi WB retired", 32'(retired), 0);
        step();
        chk("addi retired", 32'(retired), 1);
        instr_op = 6'b111111; #1;
        step(); step();
        chk("bad trap", 32'(trap), 1);
        chk("bad mem_read", 32'(mem_read), 0);
        chk("bad ir_write", 32'(ir_write), 0);
        chk("bad retired", 32'(retired), 1);
        step(); step();
        chk("bad trap held", 32'(trap), 1);
        chk("bad pc_write held", 32'(pc_write), 0);

        // lw with three not-ready cycles in MEM, then ready.
        do_reset();
        instr_op = 6'b100011; mem_ready = 1'b1; #1;
        step(); step();
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lw wait%0d mem_read", k), 32'(mem_read), 1);
            step();
        end
        mem_ready = 1'b1; #1;
        chk("lw ready mem_read", 32'(mem_read), 1);
        chk("lw ready trap", 32'(trap), 0);
        step();
        chk("lw WB reg_write", 32'(reg_write), 1);
        chk("lw WB mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw WB mem_read", 32'(mem_read), 0);
        step();
        chk("lw retired", 32'(retired), 1);

        // IF wait: four not-ready cycles then TRAP.
        do_reset();
        mem_ready = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to wait%0d trap", k), 32'(trap), 0);
            chk($sformatf("to wait%0d mem_read", k), 32'(mem_read), 1);
            step();
        end
        chk("to trap", 32'(trap), 1);
        chk("to mem_read", 32'(mem_read), 0);
        mem_ready = 1'b1; #1;
        step();
        chk("to trap held", 32'(trap), 1);
        chk("to ir_write", 32'(ir_write), 0);

        // Reset in MEM of sw abandons it and clears the count.
        do_reset();
        instr_op = 6'b001000; mem_ready = 1'b1; #1;
        step(); step(); step(); step();
        chk("sw pre retired", 32'(retired), 1);
        instr_op = 6'b101011; #1;
        step(); step();
        mem_ready = 1'b0;
        step();
        chk("sw MEM mem_write", 32'(mem_write), 1);
        rst = 1'b1; #1;
        chk("sw rst mem_write", 32'(mem_write), 0);
        chk("sw rst mem_read", 32'(mem_read), 1);
        chk("sw rst retired", 32'(retired), 0);
        @(posedge clk); #2;
        rst = 1'b0; #1;

        // Four jumps with a 2-bit counter: saturates at 3.
        do_reset();
        instr_op = 6'b000010; mem_ready = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            step(); step(); step();
            chk($sformatf("sat j%0d retired", k), 32'(retired), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
